// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes, ALUOp encodings and sequencer state type.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_SUB     = 4'b0001;
  localparam logic [3:0] ALU_MUL     = 4'b0010;
  localparam logic [3:0] ALU_AND     = 4'b0011;
  localparam logic [3:0] ALU_OR      = 4'b0100;
  localparam logic [3:0] ALU_XOR     = 4'b0101;
  localparam logic [3:0] ALU_SLL     = 4'b0110;
  localparam logic [3:0] ALU_SRL     = 4'b0111;
  localparam logic [3:0] ALU_SRA     = 4'b1000;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  localparam logic [1:0] ALUOP_LS = 2'b00;
  localparam logic [1:0] ALUOP_BR = 2'b01;
  localparam logic [1:0] ALUOP_R  = 2'b10;
  localparam logic [1:0] ALUOP_I  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULW = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of ALUOp plus instruction fields into an ALU control code.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [31:0] funct_i,
  input  logic [1:0]  ALUOp_i,
  output logic [3:0]  code,
  output logic        is_mul
);

  // Only bits 30, 25 and 14:12 carry decode information.
  logic unused_bits;
  assign unused_bits = ^{funct_i[31], funct_i[29:26], funct_i[24:15], funct_i[11:0]};

  logic [4:0] r_key;
  assign r_key = {funct_i[30], funct_i[25], funct_i[14:12]};

  // Map ALUOp class and function fields to a control code; unknown keys are ILLEGAL.
  always_comb begin
    code = ALU_ILLEGAL;
    case (ALUOp_i)
      ALUOP_LS: code = ALU_ADD;
      ALUOP_BR: code = ALU_SUB;
      ALUOP_R: begin
        case (r_key)
          5'b0_0_000: code = ALU_ADD;
          5'b1_0_000: code = ALU_SUB;
          5'b0_1_000: code = ALU_MUL;
          5'b0_0_111: code = ALU_AND;
          5'b0_0_110: code = ALU_OR;
          5'b0_0_100: code = ALU_XOR;
          5'b0_0_001: code = ALU_SLL;
          5'b0_0_101: code = ALU_SRL;
          5'b1_0_101: code = ALU_SRA;
          default:    code = ALU_ILLEGAL;
        endcase
      end
      ALUOP_I: begin
        case (funct_i[14:12])
          3'b000:  code = ALU_ADD;
          3'b111:  code = ALU_AND;
          3'b110:  code = ALU_OR;
          3'b100:  code = ALU_XOR;
          3'b001:  code = ALU_SLL;
          3'b101:  code = funct_i[30] ? ALU_SRA : ALU_SRL;
          default: code = ALU_ILLEGAL;
        endcase
      end
      default: code = ALU_ILLEGAL;
    endcase
  end

  assign is_mul = (code == ALU_MUL);

endmodule

// File: rtl/alu_op_sequencer.sv
// Accepts decode requests, stretches MUL to MUL_CYCLES latency and holds
// results until the consumer takes them. MUL_CYCLES legal range is 1..15;
// CTRL_W is expected to be at least 4.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int CTRL_W     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [31:0]       funct_i,
  input  logic [1:0]        ALUOp_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic              illegal_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       code_q, code_n;
  logic             ill_q, ill_n;
  logic [3:0]       dec_code;
  logic             dec_mul;
  logic             accept;

  alu_ctrl_decode u_dec (
    .funct_i (funct_i),
    .ALUOp_i (ALUOp_i),
    .code    (dec_code),
    .is_mul  (dec_mul)
  );

  // A new request can land when idle, or when the held result leaves this cycle.
  assign ready_o = !flush_i && ((state == ST_IDLE) || ((state == ST_HOLD) && ready_i));
  assign accept  = valid_i && ready_o;

  // Next-state, counter and result-register update; flush wins over everything.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    code_n  = code_q;
    ill_n   = ill_q;
    if (flush_i) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            code_n = dec_code;
            ill_n  = (dec_code == ALU_ILLEGAL);
            if (dec_mul && (MUL_CYCLES > 1)) begin
              cnt_n   = CNT_W'(MUL_CYCLES - 1);
              state_n = ST_MULW;
            end else begin
              state_n = ST_HOLD;
            end
          end else if ((state == ST_HOLD) && ready_i) begin
            state_n = ST_IDLE;
          end
        end
        ST_MULW: begin
          // The last wait cycle is the one where the counter reads 1.
          if (cnt == CNT_W'(1)) begin
            cnt_n   = '0;
            state_n = ST_HOLD;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      code_q <= ALU_ADD;
      ill_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      code_q <= code_n;
      ill_q  <= ill_n;
    end
  end

  assign valid_o   = (state == ST_HOLD);
  assign busy_o    = (state == ST_MULW);
  assign ALUCtrl_o = CTRL_W'(code_q);
  assign illegal_o = ill_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized plus directed bench for alu_op_sequencer, run with MUL_CYCLES=4 and 1.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst, flush, valid, ready_in;
  logic [31:0] fn;
  logic [1:0]  op;

  logic       rdy4, vld4, ill4, busy4;
  logic [3:0] code4;
  logic       rdy1, vld1, ill1, busy1;
  logic [3:0] code1;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;
  int n_edge = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.MUL_CYCLES(4), .CTRL_W(4)) u4 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(rdy4),
    .funct_i(fn), .ALUOp_i(op), .valid_o(vld4), .ready_i(ready_in),
    .ALUCtrl_o(code4), .illegal_o(ill4), .busy_o(busy4));

  alu_op_sequencer #(.MUL_CYCLES(1), .CTRL_W(4)) u1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(rdy1),
    .funct_i(fn), .ALUOp_i(op), .valid_o(vld1), .ready_i(ready_in),
    .ALUCtrl_o(code1), .illegal_o(ill1), .busy_o(busy1));

  // Reference model: a request either is absent, or exists with a known code
  // and the edge count from which its result becomes visible.
  typedef struct {
    bit         pending;
    int         ready_at;
    logic [3:0] code;
    bit         ill;
  } mdl_t;

  mdl_t m4 = '{0, 0, 4'h0, 0};
  mdl_t m1 = '{0, 0, 4'h0, 0};

  function automatic logic [3:0] ref_code(input logic [31:0] f, input logic [1:0] o);
    logic [2:0] f3;
    f3 = f[14:12];
    if (o == 2'b00) return 4'h0;
    if (o == 2'b01) return 4'h1;
    if (o == 2'b10) begin
      if (!f[25]) begin
        if (!f[30]) begin
          if (f3 == 3'b000) return 4'h0;
          if (f3 == 3'b111) return 4'h3;
          if (f3 == 3'b110) return 4'h4;
          if (f3 == 3'b100) return 4'h5;
          if (f3 == 3'b001) return 4'h6;
          if (f3 == 3'b101) return 4'h7;
        end else begin
          if (f3 == 3'b000) return 4'h1;
          if (f3 == 3'b101) return 4'h8;
        end
      end else if (!f[30] && f3 == 3'b000) return 4'h2;
      return 4'hF;
    end
    if (f3 == 3'b000) return 4'h0;
    if (f3 == 3'b111) return 4'h3;
    if (f3 == 3'b110) return 4'h4;
    if (f3 == 3'b100) return 4'h5;
    if (f3 == 3'b001) return 4'h6;
    if (f3 == 3'b101) return f[30] ? 4'h8 : 4'h7;
    return 4'hF;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input int mc, input int n_prev);
    bit vcur, acc;
    logic [3:0] c;
    vcur = m.pending && (n_prev >= m.ready_at);
    if (!rst) begin
      m.pending = 0; m.code = 4'h0; m.ill = 0;
    end else if (flush) begin
      m.pending = 0;
    end else begin
      acc = valid && (!m.pending || (vcur && ready_in));
      if (acc) begin
        c = ref_code(fn, op);
        m.pending  = 1;
        m.code     = c;
        m.ill      = (c == 4'hF);
        m.ready_at = n_prev + ((c == 4'h2) ? mc : 1);
      end else if (vcur && ready_in) begin
        m.pending = 0;
      end
    end
    return m;
  endfunction

  always @(posedge clk) begin
    m4 = mstep(m4, 4, n_edge);
    m1 = mstep(m1, 1, n_edge);
    n_edge = n_edge + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cmp_dut(input string tag, input mdl_t m, input logic r, input logic v,
                         input logic b, input logic [3:0] c, input logic i);
    bit ve, be, re;
    ve = m.pending && (n_edge >= m.ready_at);
    be = m.pending && (n_edge < m.ready_at);
    re = !flush && (!m.pending || (ve && ready_in));
    chk({tag, " valid_o"},   {31'b0, v}, {31'b0, ve});
    chk({tag, " busy_o"},    {31'b0, b}, {31'b0, be});
    chk({tag, " ready_o"},   {31'b0, r}, {31'b0, re});
    chk({tag, " ALUCtrl_o"}, {28'b0, c}, {28'b0, m.code});
    chk({tag, " illegal_o"}, {31'b0, i}, {31'b0, m.ill});
  endtask

  // Every cycle, both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut("m4", m4, rdy4, vld4, busy4, code4, ill4);
      cmp_dut("m1", m1, rdy1, vld1, busy1, code1, ill1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] o, input bit b30, input bit b25, input logic [2:0] f3);
    logic [31:0] f;
    f = '0;
    f[30] = b30;
    f[25] = b25;
    f[14:12] = f3;
    fn = f;
    op = o;
  endtask

  initial begin
    rst = 0; flush = 0; valid = 0; ready_in = 1; fn = '0; op = 2'b00;
    repeat (3) tick();
    rst = 1;
    chk_en = 1;

    // Single-cycle SUB from R-type key 1_0_000.
    set_req(2'b10, 1, 0, 3'b000); valid = 1;
    @(negedge clk); chk("sub ready_o", {31'b0, rdy4}, 32'd1);
    tick(); valid = 0;
    @(negedge clk);
    chk("sub valid_o", {31'b0, vld4}, 32'd1);
    chk("sub code", {28'b0, code4}, 32'h1);
    tick();

    // I-type funct3 010 is illegal but still handed off.
    set_req(2'b11, 0, 0, 3'b010); valid = 1;
    tick(); valid = 0;
    @(negedge clk);
    chk("ill code", {28'b0, code4}, 32'hF);
    chk("ill flag", {31'b0, ill4}, 32'd1);
    chk("ill valid_o", {31'b0, vld4}, 32'd1);
    tick();

    // MUL latency: busy for three cycles, result at the fourth.
    set_req(2'b10, 0, 1, 3'b000); valid = 1;
    tick(); valid = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("mul busy_o", {31'b0, busy4}, 32'd1);
      chk("mul ready_o", {31'b0, rdy4}, 32'd0);
      chk("mul valid_o early", {31'b0, vld4}, 32'd0);
      if (k == 1) begin
        chk("mul1 valid_o", {31'b0, vld1}, 32'd1);
        chk("mul1 code", {28'b0, code1}, 32'h2);
      end
      chk("mul1 busy_o", {31'b0, busy1}, 32'd0);
      tick();
    end
    @(negedge clk);
    chk("mul valid_o", {31'b0, vld4}, 32'd1);
    chk("mul code", {28'b0, code4}, 32'h2);
    chk("mul busy_o end", {31'b0, busy4}, 32'd0);
    tick();

    // Back-pressure on an XOR, then a back-to-back ADD.
    ready_in = 0;
    set_req(2'b11, 0, 0, 3'b100); valid = 1;
    tick(); valid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp valid_o", {31'b0, vld4}, 32'd1);
      chk("bp code", {28'b0, code4}, 32'h5);
      chk("bp ready_o", {31'b0, rdy4}, 32'd0);
      tick();
    end
    ready_in = 1; set_req(2'b00, 0, 0, 3'b000); valid = 1;
    @(negedge clk); chk("b2b ready_o", {31'b0, rdy4}, 32'd1);
    tick(); valid = 0;
    @(negedge clk);
    chk("b2b valid_o", {31'b0, vld4}, 32'd1);
    chk("b2b code", {28'b0, code4}, 32'h0);
    tick();

    // Flush at cycle 2 of a MUL with a competing request.
    set_req(2'b10, 0, 1, 3'b000); valid = 1;
    tick(); valid = 0;
    tick();
    flush = 1; set_req(2'b00, 0, 0, 3'b000); valid = 1;
    @(negedge clk); chk("flush ready_o", {31'b0, rdy4}, 32'd0);
    tick(); flush = 0; valid = 0;
    @(negedge clk);
    chk("flush valid_o", {31'b0, vld4}, 32'd0);
    chk("flush busy_o", {31'b0, busy4}, 32'd0);
    chk("flush code kept", {28'b0, code4}, 32'h2);
    tick();

    // Reset held two cycles in the middle of a MUL.
    set_req(2'b10, 0, 1, 3'b000); valid = 1;
    tick(); valid = 0;
    tick();
    rst = 0;
    tick(); tick();
    rst = 1;
    @(negedge clk);
    chk("rst valid_o", {31'b0, vld4}, 32'd0);
    chk("rst busy_o", {31'b0, busy4}, 32'd0);
    chk("rst code", {28'b0, code4}, 32'h0);
    chk("rst ready_o", {31'b0, rdy4}, 32'd1);
    tick();

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] f;
      int r;
      f = $urandom;
      r = $urandom_range(0, 3);
      if (r == 0) begin f[30] = 0; f[25] = 0; end
      else if (r == 1) begin f[30] = 0; f[25] = 1; f[14:12] = 3'b000; end
      fn       = f;
      op       = 2'($urandom_range(0, 3));
      valid    = ($urandom_range(0, 2) != 0);
      ready_in = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 19) == 0);
      rst      = ($urandom_range(0, 149) != 0);
      tick();
    end
    rst = 1; flush = 0; valid = 0;
    tick();
    @(negedge clk);
    chk_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4: cycles from MUL acceptance to result-valid; legal range 1..15.
REQ-002 SHALL have parameter CTRL_W, default 4: width of ALUCtrl_o.
REQ-003 SHALL have a single clock clk_i, and rst_i as a synchronous, active-low reset.
REQ-004 clk_i  input  1  clock; all state updates on rising edge.
REQ-005 rst_i  input  1  synchronous active-low reset.
REQ-006 flush_i  input  1  drops any in-flight operation.
REQ-007 valid_i  input  1  request present.
REQ-008 ready_o  output  1  sequencer can accept a request this cycle.
REQ-009 funct_i  input  32  instruction word; uses bits 30, 25, 14:12.
REQ-010 ALUOp_i  input  2  00 load/store, 01 branch, 10 R-type, 11 I-type.
REQ-011 valid_o  output  1  ALUCtrl_o/illegal_o valid.
REQ-012 ready_i  input  1  downstream consumes the result.
REQ-013 ALUCtrl_o  output  CTRL_W  registered ALU control code.
REQ-014 illegal_o  output  1  decoded function is unsupported.
REQ-015 busy_o  output  1  multi-cycle MUL in progress.

Function
REQ-016 Codes SHALL be: ADD 0000, SUB 0001, MUL 0010, AND 0011, OR 0100, XOR 0101, SLL 0110, SRL 0111, SRA 1000, ILLEGAL 1111.
REQ-017 ALUOp 00 SHALL decode to ADD; ALUOp 01 SHALL decode to SUB.
REQ-018 ALUOp 10 SHALL decode key {f[30],f[25],f[14:12]}: 0_0_000 ADD, 1_0_000 SUB, 0_1_000 MUL, 0_0_111 AND, 0_0_110 OR, 0_0_100 XOR, 0_0_001 SLL, 0_0_101 SRL, 1_0_101 SRA; any other key ILLEGAL.
REQ-019 ALUOp 11 SHALL decode f[14:12]: 000 ADD, 111 AND, 110 OR, 100 XOR, 001 SLL, 101 SRA if f[30] else SRL; others ILLEGAL.
REQ-020 illegal_o SHALL be 1 exactly when the registered code is ILLEGAL; an illegal request is still accepted and handed off as a single-cycle result.
REQ-021 States SHALL be IDLE, MULW, HOLD.
REQ-022 ready_o SHALL be combinational: !flush_i && (state==IDLE || (state==HOLD && ready_i)).
REQ-023 Acceptance is valid_i && ready_o at a rising edge.
REQ-024 On acceptance of a non-MUL request, or of a MUL request when MUL_CYCLES==1, the sequencer SHALL load ALUCtrl_o/illegal_o and enter HOLD; valid_o is 1 the next cycle, giving a latency of 1.
REQ-025 On acceptance of a MUL request with MUL_CYCLES>1, the sequencer SHALL load ALUCtrl_o=MUL, load the counter with MUL_CYCLES-1, and enter MULW with busy_o=1 and valid_o=0.
REQ-026 In MULW the counter SHALL decrement each cycle; when it is 1, the next state SHALL be HOLD, so valid_o rises exactly MUL_CYCLES cycles after acceptance.
REQ-027 In HOLD, valid_o=1 and the outputs SHALL stay stable until ready_i=1.
REQ-028 In HOLD, when ready_i=1 with no new acceptance, the next state SHALL be IDLE.
REQ-029 In HOLD, when ready_i=1 and a new acceptance occurs in the same cycle, the new request SHALL be loaded back-to-back with no bubble.
REQ-030 flush_i=1 SHALL force the next state to IDLE, with valid_o=0, busy_o=0 and counter=0; flush has priority over valid_i and ready_i.
REQ-031 ALUCtrl_o and illegal_o SHALL retain their last values in IDLE.
REQ-032 valid_o=1 and busy_o=1 SHALL never be asserted together.

Reset
REQ-033 When rst_i=0 at a clock edge, the sequencer SHALL go to state IDLE with valid_o=0, busy_o=0, illegal_o=0, ALUCtrl_o=0000 and counter=0; reset overrides flush and in-flight MUL.
REQ-034 Reset SHALL have no asynchronous path, so outputs change only at a clock edge.

Structure
REQ-035 Package alu_ctrl_pkg SHALL hold the code constants, ALUOp encodings and the state enum.
REQ-036 Combinational decode SHALL live in sub-module alu_ctrl_decode (inputs funct_i, ALUOp_i; outputs code, is_mul); alu_op_sequencer SHALL hold the FSM, counter and output registers.
REQ-037 Counter width SHALL be $clog2(MUL_CYCLES+1).

Verification
REQ-038 Reset: hold rst_i=0 for 2 cycles mid-MUL -> valid_o=0, busy_o=0, ALUCtrl_o=0000, ready_o=1 after release.
REQ-039 Decode sweep, single-cycle: ALUOp=10, f[30]=1, f[25]=0, f[14:12]=000 -> next cycle valid_o=1, ALUCtrl_o=0001; ALUOp=11, f[14:12]=010 -> ALUCtrl_o=1111 and illegal_o=1.
REQ-040 MUL latency (MUL_CYCLES=4): accept MUL at cycle 0 -> busy_o=1 in cycles 1-3, ready_o=0, valid_o=1 with ALUCtrl_o=0010 at cycle 4.
REQ-041 Back-pressure: hold ready_i=0 for 3 cycles in HOLD -> outputs stable, ready_o=0; then ready_i=1 with valid_i=1 (ADD) -> next cycle valid_o=1, ALUCtrl_o=0000, no gap.
REQ-042 Flush: flush_i=1 at cycle 2 of a MUL with valid_i=1 -> next cycle IDLE, valid_o=0, busy_o=0, request not accepted.
REQ-043 Parameter: MUL_CYCLES=1 -> MUL valid after 1 cycle, busy_o never 1.
